bram_rd_master: RTL and testbench
=================================

// Module: bram_rd_master
// PURPOSE
//  Initiator side of the trig/done BRAM read handshake used by the connected-domain filter.
//  Fetches i_len consecutive 32-bit words starting at i_base_addr and streams them out with valid/ready.
//  Sits between the filter's frame controller and the BRAM read port, or the BRAM read model in sim.
// PARAMETERS
//  ADDR_W       13    BRAM word-address width
//  DATA_W       32    BRAM data width
//  LEN_W        14    width of i_len (up to 2^ADDR_W words)
//  TIMEOUT_CYC  64    max cycles trig may wait for done (used only with BRAM_RD_TIMEOUT_EN)
// PORTS
//  i_clk        in   1       clock; all logic on rising edge
//  i_rst        in   1       synchronous reset, active-high
//  i_start      in   1       1-cycle pulse; latches i_base_addr/i_len when idle
//  i_base_addr  in   ADDR_W  first word address
//  i_len        in   LEN_W   number of words to read
//  o_busy       out  1       high from accepted start until o_done
//  o_done       out  1       1-cycle pulse: burst finished (last word accepted downstream, or abort)
//  o_err        out  1       sticky timeout flag, cleared by next accepted start
//  o_bram_addr  out  ADDR_W  read address, stable while o_bram_trig high
//  o_bram_trig  out  1       read request, held until i_bram_done
//  i_bram_data  in   DATA_W  read data, valid when i_bram_done high
//  i_bram_done  in   1       read complete
//  o_rd_data    out  DATA_W  output word
//  o_rd_valid   out  1       output word valid
//  i_rd_ready   in   1       downstream accept; transfer = valid & ready
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, output FIFO empty, counters 0. Reset mid-burst aborts it with no o_done.
//  FSM states: IDLE, REQ, GAP, FLUSH.
//   IDLE: i_start & i_len!=0 -> REQ, addr=i_base_addr, remaining=i_len, o_busy=1, o_err=0.
//         i_start & i_len==0 -> o_done pulse next cycle, no BRAM access.
//   REQ: o_bram_trig=1, addr frozen. On i_bram_done: capture i_bram_data into FIFO, addr+1, remaining-1,
//        trig=0 next cycle. Go to GAP; go to FLUSH if remaining becomes 0.
//   GAP: trig=0 for at least one cycle so the responder clears its latency counter.
//        Go to REQ when FIFO has a free slot.
//   FLUSH: wait for FIFO empty -> o_done pulse, o_busy=0, -> IDLE.
//  i_start outside IDLE is ignored. i_bram_done outside REQ is ignored.
//  Address increments mod 2^ADDR_W (0x1FFF -> 0x0000); no error on wrap.
//  REQ is entered only with a free FIFO slot, so capture never overflows.
//  Throughput: one word per (responder latency + 2) cycles; first o_rd_valid is 1 cycle after first done.
//  Output FIFO is 2 deep, first-word-fall-through. Push and pop in the same cycle are legal.
//  o_rd_data holds its value while valid & !ready.
// CONFIGURATION
//  BRAM_RD_TIMEOUT_EN defined:
//   - cycle counter runs in REQ.
//   - TIMEOUT_CYC cycles without done: trig=0, o_err=1, FIFO flushed, o_done pulse, -> IDLE.
//  Not defined: no counter; REQ waits indefinitely; o_err tied 0.
// STRUCTURE
//  Package bram_rd_pkg: ADDR_W/DATA_W/LEN_W defaults, FSM state enum typedef, FIFO depth constant.
//  Sub-module bram_rd_ofifo: 2-entry FWD FIFO (push, pop, full, empty, data); FSM and counters stay in the top.
// TESTING (responder: latency 1; addr0=0x12345678, addr1=0x87654321, others 0xFFFFFFFF)
//  1. start base=0 len=2, ready=1
//     -> outputs 0x12345678 then 0x87654321; trig low >=1 cycle between reads; one o_done; o_busy cleared.
//  2. len=0 -> o_done the cycle after start; o_bram_trig never asserts.
//  3. base=0x1FFF len=3 -> addresses 0x1FFF, 0x0000, 0x0001; data 0xFFFFFFFF, 0x12345678, 0x87654321.
//  4. len=4, ready low 20 cycles
//     -> at most 2 reads complete, trig idle, data held stable; all 4 words delivered in order after release.
//  5. i_rst high mid-burst (after 1st done)
//     -> next cycle trig=0, valid=0, busy=0, no o_done; a new start then runs normally.
//  6. BRAM_RD_TIMEOUT_EN, responder done never asserted
//     -> o_err=1 and o_done after 64 REQ cycles; next start clears o_err.

Source files
------------

// File: rtl/bram_rd_pkg.sv
// Shared defaults, FSM state type and output FIFO depth for the BRAM read master.
package bram_rd_pkg;

  localparam int ADDR_W_DEF      = 13;
  localparam int DATA_W_DEF      = 32;
  localparam int LEN_W_DEF       = 14;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int FIFO_DEPTH      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/bram_rd_ofifo.sv
// Two-entry first-word-fall-through output FIFO; simultaneous push and pop allowed.
module bram_rd_ofifo
  import bram_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign o_full  = (count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (count == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  // Drive zero when empty so the output is defined straight out of reset.
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/bram_rd_master.sv
// Trig/done BRAM read initiator: fetches a burst of words and streams them out via valid/ready.
// Optional REQ watchdog enabled by defining BRAM_RD_TIMEOUT_EN.
module bram_rd_master
  import bram_rd_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_bram_trig,
  input  logic [DATA_W-1:0] i_bram_data,
  input  logic              i_bram_done,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              timeout_hit;

`ifdef BRAM_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counter only runs while a request is outstanding; any other state rearms it.
  always_ff @(posedge i_clk) begin
    if (i_rst || state != ST_REQ) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign timeout_hit = (state == ST_REQ) && !i_bram_done &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign fifo_push   = (state == ST_REQ) && i_bram_done;
  assign fifo_pop    = o_rd_valid && i_rd_ready;
  assign o_rd_valid  = !fifo_empty;
  assign o_bram_addr = addr;

  bram_rd_ofifo #(
    .DATA_W (DATA_W)
  ) u_ofifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_flush (timeout_hit),
    .i_data  (i_bram_data),
    .o_data  (o_rd_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_bram_trig <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_err <= 1'b0;
            if (i_len != '0) begin
              state       <= ST_REQ;
              addr        <= i_base_addr;
              remaining   <= i_len;
              o_busy      <= 1'b1;
              o_bram_trig <= 1'b1;
            end else begin
              o_done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // A done arriving on the last watchdog cycle still wins over the timeout.
          if (i_bram_done) begin
            o_bram_trig <= 1'b0;
            addr        <= addr + ADDR_W'(1);
            remaining   <= remaining - LEN_W'(1);
            state       <= (remaining == LEN_W'(1)) ? ST_FLUSH : ST_GAP;
          end else if (timeout_hit) begin
            o_bram_trig <= 1'b0;
            o_err       <= 1'b1;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (!fifo_full) begin
            o_bram_trig <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_rd_master.sv
// Directed bench for bram_rd_master with a latency-1 trig/done BRAM responder model.
module tb_bram_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [12:0] i_base_addr;
  logic [13:0] i_len;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [12:0] o_bram_addr;
  logic        o_bram_trig;
  logic [31:0] i_bram_data;
  logic        i_bram_done;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic        rsp_en;

  int checks   = 0;
  int failures = 0;

  int n_done     = 0;
  int n_reads    = 0;
  int n_trig_cyc = 0;
  int n_viol     = 0;
  logic prev_done = 1'b0;
  logic [31:0] out_q [$];
  logic [12:0] addr_q [$];

  always #5 clk = ~clk;

  bram_rd_master dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_bram_addr (o_bram_addr),
    .o_bram_trig (o_bram_trig),
    .i_bram_data (i_bram_data),
    .i_bram_done (i_bram_done),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .i_rd_ready  (i_rd_ready)
  );

  function automatic logic [31:0] mem_word(input logic [12:0] a);
    if (a == 13'h0000) return 32'h12345678;
    if (a == 13'h0001) return 32'h87654321;
    return 32'hFFFFFFFF;
  endfunction

  // Responder: done one cycle after it sees trig, then drops so trig can fall.
  always @(posedge clk) begin
    if (rsp_en && o_bram_trig && !i_bram_done) begin
      i_bram_done <= 1'b1;
      i_bram_data <= mem_word(o_bram_addr);
    end else begin
      i_bram_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (o_done) n_done++;
    if (!rst) begin
      if (o_bram_trig && i_bram_done) begin
        n_reads++;
        addr_q.push_back(o_bram_addr);
      end
      if (o_bram_trig) n_trig_cyc++;
      if (prev_done && o_bram_trig) n_viol++;
      if (o_rd_valid && i_rd_ready) out_q.push_back(o_rd_data);
    end
    prev_done = i_bram_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [12:0] base, input logic [13:0] len);
    @(posedge clk); #1;
    i_start     = 1'b1;
    i_base_addr = base;
    i_len       = len;
    @(posedge clk); #1;
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) break;
    end
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  task automatic clear_logs();
    @(posedge clk); #1;
    out_q.delete();
    addr_q.delete();
  endtask

  int d_done, d_reads, d_trig, d_viol;

  initial begin
    rst         = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_len       = '0;
    i_rd_ready  = 1'b1;
    rsp_en      = 1'b1;
    i_bram_done = 1'b0;
    i_bram_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_trig", 32'(o_bram_trig), 32'd0);
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_addr", 32'(o_bram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: base 0, len 2
    clear_logs();
    d_done = n_done; d_viol = n_viol;
    do_start(13'h0000, 14'd2);
    chk("t1_busy", 32'(o_busy), 32'd1);
    wait_done(100, "t1_done_seen");
    chk("t1_busy_clr", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk("t1_nwords", 32'(out_q.size()), 32'd2);
    chk("t1_w0", out_q[0], 32'h12345678);
    chk("t1_w1", out_q[1], 32'h87654321);
    chk("t1_ndone", 32'(n_done - d_done), 32'd1);
    chk("t1_trig_gap", 32'(n_viol - d_viol), 32'd0);

    // 2: len 0
    d_trig = n_trig_cyc;
    do_start(13'h0005, 14'd0);
    @(negedge clk);
    chk("t2_done", 32'(o_done), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_no_trig", 32'(n_trig_cyc - d_trig), 32'd0);
    chk("t2_busy", 32'(o_busy), 32'd0);

    // 3: address wrap
    clear_logs();
    do_start(13'h1FFF, 14'd3);
    wait_done(100, "t3_done_seen");
    @(posedge clk); #1;
    chk("t3_a0", 32'(addr_q[0]), 32'h1FFF);
    chk("t3_a1", 32'(addr_q[1]), 32'h0000);
    chk("t3_a2", 32'(addr_q[2]), 32'h0001);
    chk("t3_nwords", 32'(out_q.size()), 32'd3);
    chk("t3_w0", out_q[0], 32'hFFFFFFFF);
    chk("t3_w1", out_q[1], 32'h12345678);
    chk("t3_w2", out_q[2], 32'h87654321);

    // 4: backpressure
    clear_logs();
    i_rd_ready = 1'b0;
    d_reads = n_reads;
    do_start(13'h0000, 14'd4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_hold_early", o_rd_data, 32'h12345678);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t4_reads", 32'(n_reads - d_reads), 32'd2);
    chk("t4_trig_idle", 32'(o_bram_trig), 32'd0);
    chk("t4_valid", 32'(o_rd_valid), 32'd1);
    chk("t4_hold_late", o_rd_data, 32'h12345678);
    @(posedge clk); #1;
    i_rd_ready = 1'b1;
    wait_done(100, "t4_done_seen");
    @(posedge clk); #1;
    chk("t4_nwords", 32'(out_q.size()), 32'd4);
    chk("t4_w0", out_q[0], 32'h12345678);
    chk("t4_w1", out_q[1], 32'h87654321);
    chk("t4_w2", out_q[2], 32'hFFFFFFFF);
    chk("t4_w3", out_q[3], 32'hFFFFFFFF);

    // 5: reset mid-burst
    begin
      int i;
      do_start(13'h0000, 14'd4);
      for (i = 0; i < 50; i++) begin
        @(negedge clk);
        if (o_bram_trig && i_bram_done) break;
      end
      chk("t5_first_done", 32'(i < 50), 32'd1);
    end
    d_done = n_done;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_trig", 32'(o_bram_trig), 32'd0);
    chk("t5_valid", 32'(o_rd_valid), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(n_done - d_done), 32'd0);
    clear_logs();
    do_start(13'h0000, 14'd2);
    wait_done(100, "t5_restart_done");
    @(posedge clk); #1;
    chk("t5_nwords", 32'(out_q.size()), 32'd2);
    chk("t5_w0", out_q[0], 32'h12345678);
    chk("t5_w1", out_q[1], 32'h87654321);

`ifdef BRAM_RD_TIMEOUT_EN
    // 6: responder silent, watchdog fires
    rsp_en = 1'b0;
    d_trig = n_trig_cyc;
    do_start(13'h0000, 14'd2);
    wait_done(200, "t6_done_seen");
    chk("t6_err", 32'(o_err), 32'd1);
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_valid", 32'(o_rd_valid), 32'd0);
    @(posedge clk); #1;
    chk("t6_trig_cycles", 32'(n_trig_cyc - d_trig), 32'd64);
    rsp_en = 1'b1;
    clear_logs();
    do_start(13'h0000, 14'd1);
    chk("t6_err_clr", 32'(o_err), 32'd0);
    wait_done(100, "t6_restart_done");
    @(posedge clk); #1;
    chk("t6_w0", out_q[0], 32'h12345678);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
